// File: rtl/uart_tx_serializer.sv
// UART transmitter: edge-detects baud_in into ticks, buffers host bytes in a FIFO and shifts out framed bits.
// tx is registered and moves one clk after the tick that ends a bit; tx_ready drops only when the FIFO is full.
module uart_tx_serializer #(
  parameter int DATA_BITS     = 8,
  parameter int TICKS_PER_BIT = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         baud_in,
  input  logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic                 baud_q;
  logic                 tick;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_q, par_n;
  logic                 tx_q, tx_n;
  logic                 bit_end;

  // baud_q resets high like the generator output, so the first tick is a genuine rising edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) baud_q <= 1'b1;
    else          baud_q <= baud_in;
  end
  assign tick = baud_in & ~baud_q;

  assign tx_ready   = (count < DEPTH);
  assign push       = tx_valid & tx_ready;
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par_q    <= par_n;
      tx_q     <= tx_n;
    end
  end

  assign bit_end = tick && (tick_cnt == LAST_TICK);

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_n      = par_q;
    pop        = 1'b0;
    tx_n       = 1'b1;

    if (tick && state != IDLE) tick_cnt_n = bit_end ? '0 : tick_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (tick && count != '0) begin
          pop        = 1'b1;
          tick_cnt_n = '0;
          state_n    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = '0;
            state_n   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          if (bit_cnt != LAST_STOP) bit_cnt_n = bit_cnt + 4'd1;
          else if (count != '0) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // parity is latched from the popped byte, since the shift register is consumed during DATA
    if (pop) begin
      shift_n = head;
      par_n   = (PARITY_ODD != 0) ? ~^head : ^head;
    end

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state != IDLE);

endmodule
